// File: rtl/div_by_n.sv
// Integer clock divider: out has a period of exactly DIV_VALUE clk cycles.
// Define DIV_BY_N_DUTY50_EN to add a negedge retiming flop that gives odd ratios a 50% duty cycle.
`timescale 1ns / 1ps

module div_by_n #(
   parameter int unsigned DIV_VALUE = 5
) (
   input  logic clk,
   input  logic rst,
   output logic out
);

   localparam int unsigned CntW = (DIV_VALUE < 2) ? 1 : $clog2(DIV_VALUE);
   localparam logic [CntW-1:0] CntMax  = CntW'(DIV_VALUE - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(DIV_VALUE / 2);

   if (DIV_VALUE < 2 || DIV_VALUE > 65535) begin : g_bad_div_value
      $error("div_by_n: DIV_VALUE=%0d outside legal range 2..65535", DIV_VALUE);
   end

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            pos_q, pos_d;

   // pos_q is high while the pre-edge count is in the first half of the period.
   always_comb begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      pos_d = (cnt_q < CntHalf);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         pos_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pos_q <= pos_d;
      end
   end

`ifdef DIV_BY_N_DUTY50_EN
   localparam bit OddN = (DIV_VALUE % 2) == 1;

   if (OddN) begin : g_duty50
      logic neg_q, neg_d;

      always_comb begin
         neg_d = pos_q;
      end

      always_ff @(negedge clk or negedge rst) begin
         if (!rst) begin
            neg_q <= 1'b0;
         end else begin
            neg_q <= neg_d;
         end
      end

      // Only one OR input changes at each transition, so the output cannot glitch.
      assign out = pos_q | neg_q;
   end else begin : g_pos_only
      assign out = pos_q;
   end
`else
   assign out = pos_q;
`endif

endmodule

// File: tb/tb_div_by_n.sv
// Directed self-checking bench for div_by_n: sweeps N=2..17 against a time-based model
// and checks reset pulses on a separate N=5 instance.
`timescale 1ns / 1ps

module tb_div_by_n;

`ifdef DIV_BY_N_DUTY50_EN
   localparam bit Duty50 = 1'b1;
`else
   localparam bit Duty50 = 1'b0;
`endif

   logic        clk;
   logic        rst_a;
   logic        rst_b;
   logic [17:2] sweep_out;
   logic        p_out;

   int checks;
   int failures;

   for (genvar n = 2; n <= 17; n++) begin : g_dut
      div_by_n #(.DIV_VALUE(n)) u_dut (
         .clk (clk),
         .rst (rst_a),
         .out (sweep_out[n])
      );
   end

   div_by_n #(.DIV_VALUE(5)) u_pulse (
      .clk (clk),
      .rst (rst_b),
      .out (p_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected out at time t for ratio n when period 0 starts at time start.
   function automatic logic exp_out(input int n, input longint t, input longint start);
      longint ph;
      longint hd;
      if (t < start) return 1'b0;
      ph = (t - start) % (10 * n);
      hd = 10 * (n / 2) + ((((n % 2) == 1) && Duty50) ? 5 : 0);
      return (ph < hd);
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic wait_until(input longint t);
      if (t > $time) #(t - $time);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_a    = 1'b0;
      rst_b    = 1'b0;

      wait_until(3);
      for (int n = 2; n <= 17; n++) chk("reset_out", sweep_out[n], 1'b0);
      chk("reset_pulse_dut", p_out, 1'b0);
      wait_until(8);
      for (int n = 2; n <= 17; n++) chk("reset_held", sweep_out[n], 1'b0);
      wait_until(10);
      rst_a = 1'b1;
      rst_b = 1'b1;

      // Sample 1 ns after every clk edge.
      for (longint t = 11; t <= 1806; t += 5) begin
         wait_until(t);
         for (int n = 2; n <= 17; n++) begin
            chk($sformatf("sweep_n%0d", n), sweep_out[n], exp_out(n, t, 15));
         end
         if (t < 52) chk("pulse_pre", p_out, exp_out(5, t, 15));
         else if (t >= 76) chk("pulse_post", p_out, exp_out(5, t, 75));

         case (t)
            11: chk("n5_before_rise", sweep_out[5], 1'b0);
            16: begin
               chk("n5_rise15", sweep_out[5], 1'b1);
               chk("n4_rise15", sweep_out[4], 1'b1);
               chk("n2_rise15", sweep_out[2], 1'b1);
               chk("n3_rise15", sweep_out[3], 1'b1);
            end
            26: begin
               chk("n2_fall25", sweep_out[2], 1'b0);
               chk("n3_at26", sweep_out[3], Duty50);
            end
            31: chk("n3_low31", sweep_out[3], 1'b0);
            36: begin
               chk("n5_at36", sweep_out[5], Duty50);
               chk("n4_fall35", sweep_out[4], 1'b0);
               chk("n2_rise35", sweep_out[2], 1'b1);
            end
            41: chk("n5_fall_by40", sweep_out[5], 1'b0);
            46: chk("n3_rise45", sweep_out[3], 1'b1);
            51: begin
               #1 rst_b = 1'b0;
            end
            56: begin
               chk("pulse_held_low", p_out, 1'b0);
               chk("n4_rise55", sweep_out[4], 1'b1);
               #2 rst_b = 1'b1;
            end
            61: chk("pulse_wait_edge", p_out, 1'b0);
            66: begin
               chk("pulse_rise65", p_out, 1'b1);
               chk("n5_rise65", sweep_out[5], 1'b1);
               #1 rst_b = 1'b0;
               #1 chk("pulse_async_drop", p_out, 1'b0);
            end
            71: begin
               chk("pulse_held_again", p_out, 1'b0);
               #2 rst_b = 1'b1;
            end
            76: begin
               chk("pulse_rise75", p_out, 1'b1);
               chk("n4_fall75", sweep_out[4], 1'b0);
            end
            91: chk("n5_fall_by90", sweep_out[5], 1'b0);
            96: chk("n4_rise95", sweep_out[4], 1'b1);
            default: ;
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
